// File: rtl/fir_stream_ntap.sv
`default_nettype none
// ==========================================================================
// fir_stream_ntap : N-tap streaming FIR, valid/ready, double-buffered coefs
// Revision 1.0
// ==========================================================================
module fir_stream_ntap #(
  parameter int TAPS        = 5,
  parameter int DATA_W      = 16,
  parameter int COEF_W      = 8,
  parameter int ACC_W       = 32,
  parameter int OUT_W       = 16,
  parameter int SHIFT       = 6,
  parameter bit CLR_ON_SWAP = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  x_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   y_out,
  output logic                      out_sat,
  input  logic                      coef_wr,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  input  logic                      coef_commit,
  output logic                      coef_busy
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SWAP  = 2'd2;
  localparam logic signed [COEF_W-1:0] UNITY   = COEF_W'(1 << SHIFT);
  localparam logic signed [ACC_W-1:0]  RND     = ACC_W'(1 << (SHIFT - 1));
  localparam logic signed [ACC_W-1:0]  OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]               state_q, state_d;
  logic signed [COEF_W-1:0] active_q [TAPS];
  logic signed [COEF_W-1:0] active_d [TAPS];
  logic signed [COEF_W-1:0] shadow_q [TAPS];
  logic signed [COEF_W-1:0] shadow_d [TAPS];
  logic signed [DATA_W-1:0] hist_q   [TAPS];
  logic signed [DATA_W-1:0] hist_d   [TAPS];
  logic signed [PROD_W-1:0] prod     [TAPS];
  logic signed [ACC_W-1:0]  p_q      [TAPS];
  logic signed [ACC_W-1:0]  p_d      [TAPS];
  logic                     p_valid_q, p_valid_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  y_q, y_d;
  logic                     sat_q, sat_d;
  logic signed [ACC_W-1:0]  acc, rnd;
  logic                     adv, accept, do_swap;

  // FSM next state: drain leaves only once stage P is empty and stage S can move
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (coef_commit) state_d = ST_DRAIN;
      ST_DRAIN: if (!p_valid_q && adv) state_d = ST_SWAP;
      ST_SWAP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    adv       = ~out_valid_q | out_ready;
    in_ready  = adv && (state_q == ST_IDLE);
    coef_busy = (state_q != ST_IDLE);
    do_swap   = (state_q == ST_SWAP);
    accept    = in_valid & in_ready;
  end

  // Active copies the pre-write shadow value on a same-cycle write in SWAP
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      active_d[k] = do_swap ? shadow_q[k] : active_q[k];
      shadow_d[k] = (coef_wr && int'(coef_addr) == k) ? coef_data : shadow_q[k];
    end
  end

  always_comb begin
    for (int k = 0; k < TAPS; k++) hist_d[k] = hist_q[k];
    if (accept) begin
      hist_d[0] = x_in;
      for (int k = 1; k < TAPS; k++) hist_d[k] = hist_q[k-1];
    end else if (do_swap && CLR_ON_SWAP) begin
      for (int k = 0; k < TAPS; k++) hist_d[k] = '0;
    end
  end

  // Products use the post-accept history so an accepted sample reaches P at once
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod[k] = active_q[k] * hist_d[k];
      p_d[k]  = adv ? {{(ACC_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]} : p_q[k];
    end
    p_valid_d = adv ? accept : p_valid_q;
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + p_q[k];
    rnd = (acc + RND) >>> SHIFT;
    y_d         = y_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    if (adv) begin
      out_valid_d = p_valid_q;
      if (rnd > OUT_MAX) begin
        y_d   = OUT_MAX[OUT_W-1:0];
        sat_d = 1'b1;
      end else if (rnd < OUT_MIN) begin
        y_d   = OUT_MIN[OUT_W-1:0];
        sat_d = 1'b1;
      end else begin
        y_d   = rnd[OUT_W-1:0];
        sat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      p_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      sat_q       <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        active_q[k] <= (k == 0) ? UNITY : '0;
        shadow_q[k] <= (k == 0) ? UNITY : '0;
        hist_q[k]   <= '0;
        p_q[k]      <= '0;
      end
    end else begin
      state_q     <= state_d;
      p_valid_q   <= p_valid_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      sat_q       <= sat_d;
      for (int k = 0; k < TAPS; k++) begin
        active_q[k] <= active_d[k];
        shadow_q[k] <= shadow_d[k];
        hist_q[k]   <= hist_d[k];
        p_q[k]      <= p_d[k];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign y_out     = y_q;
  assign out_sat   = sat_q;

endmodule
`default_nettype wire

// File: doc/fir_stream_ntap.md
Name: fir_stream_ntap

Overview:
- Parametrised N-tap FIR filter for the streaming datapath; next generation of the fixed five-tap systolic filter.
- Generalised in tap count and widths.
- Adds valid/ready handshakes on input and output, a double-buffered runtime coefficient bank with a drain-and-swap FSM, and round-half-up / saturate output scaling.
- Sits between the sample source and downstream consumers.

Parameters:
TAPS, 5, number of taps (>=2)
DATA_W, 16, signed input sample width
COEF_W, 8, signed coefficient width
ACC_W, 32, accumulator width; must be >= DATA_W+COEF_W+clog2(TAPS)
OUT_W, 16, signed output width
SHIFT, 6, output right-shift (Q format of coefficients); 1 <= SHIFT <= COEF_W-2
CLR_ON_SWAP, 1, 1 = zero the sample history when a new coefficient bank goes live

Ports:
clk  in  1  rising-edge clock, the only clock
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  x_in valid
in_ready  out  1  block accepts x_in this cycle
x_in  in  DATA_W  signed sample
out_valid  out  1  y_out valid
out_ready  in  1  consumer accepts y_out
y_out  out  OUT_W  signed filtered sample
out_sat  out  1  y_out was clipped; qualified by out_valid
coef_wr  in  1  write coef_data into shadow bank
coef_addr  in  clog2(TAPS)  shadow tap index; values >= TAPS are ignored
coef_data  in  COEF_W  signed coefficient
coef_commit  in  1  request shadow-to-active swap (pulse)
coef_busy  out  1  commit pending or in progress

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, y_out=0, out_sat=0, coef_busy=0.
  - Stage valids 0; history all 0; FSM=IDLE.
  - Active and shadow banks: tap0 = 2^SHIFT, all others 0, so the filter is an identity passthrough.
- Global advance: adv = ~out_valid | out_ready.
  - All pipeline registers hold when adv=0.
  - in_ready = adv & (state==IDLE). It is combinational from out_valid, out_ready and state.
- Accept = in_valid & in_ready.
  - On accept: hist[0] <= x_in; hist[k] <= hist[k-1].
  - Without an accept, history is unchanged. Bubbles do not shift history.
- Stage 1 (P): registered when adv.
  - p[k] = active[k] * hist[k] (signed, sign-extended to ACC_W); p_valid <= accept of previous cycle.
- Stage 2 (S): registered when adv.
  - acc = sum of p[k].
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift).
  - If r > 2^(OUT_W-1)-1 or r < -2^(OUT_W-1): clip to that bound and set out_sat=1; else out_sat=0.
  - The result loads y_out; out_valid <= p_valid.
- Latency: sample accepted in cycle t appears with out_valid=1 in cycle t+2 when there is no backpressure. One sample per cycle sustained.
- Backpressure: while out_valid & ~out_ready, y_out, out_sat and out_valid are held stable and in_ready=0.
- Coefficient FSM: IDLE -> DRAIN -> SWAP -> IDLE.
  - coef_wr: writes the shadow bank in any state, takes effect the next cycle, and never disturbs the active bank.
  - IDLE: on coef_commit go to DRAIN; coef_busy=1 from the next cycle.
  - DRAIN: in_ready=0. When p_valid=0 and (out_valid=0 or out_ready=1), go to SWAP.
  - SWAP (1 cycle): active <= shadow; if CLR_ON_SWAP, history <= 0; then IDLE, coef_busy=0.
  - Samples accepted before the commit are filtered with the old bank. Samples accepted after it use the new bank.
  - Commit in the same cycle as an accept: the accept completes (old bank).
  - coef_commit while busy: ignored.
  - coef_wr in SWAP at the same address: the shadow is updated; active gets the pre-write value.
- Reset mid-operation: all in-flight samples and any pending commit are discarded. Shadow contents revert to the reset values.

Test Plan:
1. Reset release, feed 100, -7, 32767 back-to-back with out_ready=1 -> y_out 100, -7, 32767 at accept+2 cycles; out_sat=0.
2. Load all taps = 64, commit, wait coef_busy=0, then feed 10, 20, 30, 40, 50, 0 -> y_out 10, 30, 60, 100, 150, 140.
3. All taps = 127, feed 32767 x5 -> fifth output 32767 with out_sat=1. All taps = 127, feed -32768 x5 -> fifth output -32768, out_sat=1.
4. Rounding: tap0 = 32, others 0; feed -3, 3, 1 -> y_out -1, 2, 1.
5. Hold out_ready=0 for 4 cycles with out_valid=1 -> y_out stable, in_ready=0, no samples lost. Release -> output stream continues in order with no duplicates.
6. Assert coef_commit while two samples are in flight -> both emerge with the old-bank values, in_ready stays 0 through DRAIN/SWAP, next sample uses the new bank. Assert rst_n low mid-stream -> out_valid=0 immediately, identity bank restored.
